// File: rtl/video_timing_pkg.sv
// -----------------------------------------------------------------------------
// video_timing_pkg
// Shared definitions for the video timing generator.
//   SYNC_ACT_HIGH / SYNC_ACT_LOW : values for the HS_POL / VS_POL parameters
//   timing_total()                : active + front porch + sync + back porch
//   sync_start()                  : first position at which sync is asserted
//   sync_end()                    : first position after sync (exclusive bound)
// -----------------------------------------------------------------------------
package video_timing_pkg;

   localparam bit SYNC_ACT_HIGH = 1'b1;
   localparam bit SYNC_ACT_LOW  = 1'b0;

   function automatic int unsigned timing_total(input int unsigned res,
                                                input int unsigned fp,
                                                input int unsigned sync,
                                                input int unsigned bp);
      return res + fp + sync + bp;
   endfunction

   function automatic int unsigned sync_start(input int unsigned res,
                                              input int unsigned fp);
      return res + fp;
   endfunction

   function automatic int unsigned sync_end(input int unsigned res,
                                            input int unsigned fp,
                                            input int unsigned sync);
      return res + fp + sync;
   endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// -----------------------------------------------------------------------------
// video_timing_gen_if
// Bundle between the timing generator (master) and its consumer (slave).
//   enable, div           : run/freeze control and pixel divider select (to gen)
//   pix_ena               : last pclk of each pixel period
//   h_pos, v_pos          : current pixel coordinates
//   hde, vde, de          : display enables
//   hsync, vsync          : sync at the configured polarity
//   line_start, frame_start : position markers, held for a whole pixel period
// -----------------------------------------------------------------------------
interface video_timing_gen_if #(
   parameter int CW    = 12,
   parameter int DIV_W = 4
) ();
   logic             enable;
   logic [DIV_W-1:0] div;
   logic             pix_ena;
   logic [CW-1:0]    h_pos;
   logic [CW-1:0]    v_pos;
   logic             hde;
   logic             vde;
   logic             de;
   logic             hsync;
   logic             vsync;
   logic             line_start;
   logic             frame_start;

   modport master (
      input  enable, div,
      output pix_ena, h_pos, v_pos, hde, vde, de, hsync, vsync,
             line_start, frame_start
   );

   modport slave (
      output enable, div,
      input  pix_ena, h_pos, v_pos, hde, vde, de, hsync, vsync,
             line_start, frame_start
   );
endinterface

// File: rtl/pix_ce_div.sv
// -----------------------------------------------------------------------------
// pix_ce_div
// Pixel clock-enable divider.
//   pclk, reset : clock, synchronous active-high reset
//   enable      : low freezes the divider and forces pix_ena low
//   div         : pixel period in pclks minus 1; sampled on reset and frame wrap
//   frame_end   : high while the position counters sit on the last pixel
//   pix_ena     : high in the last pclk of each pixel period
// -----------------------------------------------------------------------------
module pix_ce_div #(
   parameter int DIV_W = 4
) (
   input  logic             pclk,
   input  logic             reset,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   input  logic             frame_end,
   output logic             pix_ena
);
   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [DIV_W-1:0] div_sel_q, div_sel_d;
   logic             pix_ena_s;

   // Next divider phase; the latched divide value only changes when the
   // frame actually wraps, so a frozen wrap also defers the reload.
   always_comb begin
      pix_ena_s = enable & (div_cnt_q == div_sel_q);
      div_cnt_d = div_cnt_q;
      div_sel_d = div_sel_q;
      if (pix_ena_s) begin
         div_cnt_d = {DIV_W{1'b0}};
         if (frame_end) begin
            div_sel_d = div;
         end else begin
            div_sel_d = div_sel_q;
         end
      end else if (enable) begin
         div_cnt_d = div_cnt_q + DIV_W'(1);
      end else begin
         div_cnt_d = div_cnt_q;
      end
   end

   // Divider state registers.
   always_ff @(posedge pclk) begin
      if (reset) begin
         div_cnt_q <= {DIV_W{1'b0}};
         div_sel_q <= div;
      end else begin
         div_cnt_q <= div_cnt_d;
         div_sel_q <= div_sel_d;
      end
   end

   assign pix_ena = pix_ena_s;
endmodule

// File: rtl/video_timing_gen_chk.sv
// -----------------------------------------------------------------------------
// video_timing_gen_chk
// Elaboration-time parameter checks for video_timing_gen. No ports: it only
// refuses to elaborate when the counter width cannot reach the last position
// or when a porch/sync width is zero.
// -----------------------------------------------------------------------------
module video_timing_gen_chk #(
   parameter int unsigned CW     = 12,
   parameter int unsigned H_TOT  = 800,
   parameter int unsigned V_TOT  = 525,
   parameter int unsigned H_FP   = 16,
   parameter int unsigned H_SYNC = 96,
   parameter int unsigned H_BP   = 48,
   parameter int unsigned V_FP   = 10,
   parameter int unsigned V_SYNC = 2,
   parameter int unsigned V_BP   = 33
) ();
   if (64'(H_TOT - 32'd1) >= (64'd1 << CW)) begin : g_h_width
      $error("video_timing_gen: CW too narrow for H_TOT-1");
   end
   if (64'(V_TOT - 32'd1) >= (64'd1 << CW)) begin : g_v_width
      $error("video_timing_gen: CW too narrow for V_TOT-1");
   end
   if (H_FP == 32'd0 || H_SYNC == 32'd0 || H_BP == 32'd0) begin : g_h_zero
      $error("video_timing_gen: horizontal porch/sync width is zero");
   end
   if (V_FP == 32'd0 || V_SYNC == 32'd0 || V_BP == 32'd0) begin : g_v_zero
      $error("video_timing_gen: vertical porch/sync width is zero");
   end
endmodule

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
// Parametrised raster timing generator.
//   pclk  : base pixel clock
//   reset : synchronous active-high, restarts the frame at (0,0)
//   vt    : master side of video_timing_gen_if (enable/div in, timing out)
// Position counters advance on pix_ena; every decoded output is registered
// from the next-state position so it always matches h_pos/v_pos.
// -----------------------------------------------------------------------------
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned H_RES  = 640,
   parameter int unsigned H_FP   = 16,
   parameter int unsigned H_SYNC = 96,
   parameter int unsigned H_BP   = 48,
   parameter int unsigned V_RES  = 480,
   parameter int unsigned V_FP   = 10,
   parameter int unsigned V_SYNC = 2,
   parameter int unsigned V_BP   = 33,
   parameter bit          HS_POL = SYNC_ACT_HIGH,
   parameter bit          VS_POL = SYNC_ACT_HIGH,
   parameter int          CW     = 12,
   parameter int          DIV_W  = 4
) (
   input  logic                pclk,
   input  logic                reset,
   video_timing_gen_if.master  vt
);
   localparam int unsigned H_TOT = timing_total(H_RES, H_FP, H_SYNC, H_BP);
   localparam int unsigned V_TOT = timing_total(V_RES, V_FP, V_SYNC, V_BP);

   localparam logic [CW-1:0] H_LAST = CW'(H_TOT - 32'd1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOT - 32'd1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_RES);
   localparam logic [CW-1:0] V_ACT  = CW'(V_RES);
   localparam logic [CW-1:0] HS_BEG = CW'(sync_start(H_RES, H_FP));
   localparam logic [CW-1:0] HS_END = CW'(sync_end(H_RES, H_FP, H_SYNC));
   localparam logic [CW-1:0] VS_BEG = CW'(sync_start(V_RES, V_FP));
   localparam logic [CW-1:0] VS_END = CW'(sync_end(V_RES, V_FP, V_SYNC));

   video_timing_gen_chk #(
      .CW(CW), .H_TOT(H_TOT), .V_TOT(V_TOT),
      .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_chk ();

   logic          pix_ena_s;
   logic          frame_end_s;
   logic [CW-1:0] h_pos_q, h_pos_d;
   logic [CW-1:0] v_pos_q, v_pos_d;
   logic          hde_q, hde_d, vde_q, vde_d, de_q, de_d;
   logic          hsync_q, hsync_d, vsync_q, vsync_d;
   logic          line_start_q, line_start_d, frame_start_q, frame_start_d;

   assign frame_end_s = (h_pos_q == H_LAST) && (v_pos_q == V_LAST);

   pix_ce_div #(.DIV_W(DIV_W)) u_div (
      .pclk      (pclk),
      .reset     (reset),
      .enable    (vt.enable),
      .div       (vt.div),
      .frame_end (frame_end_s),
      .pix_ena   (pix_ena_s)
   );

   // Next position, then decode of that next position so the registered
   // flags land in the same cycle as the coordinates they describe.
   always_comb begin
      h_pos_d = h_pos_q;
      v_pos_d = v_pos_q;
      if (pix_ena_s) begin
         if (h_pos_q == H_LAST) begin
            h_pos_d = {CW{1'b0}};
            if (v_pos_q == V_LAST) begin
               v_pos_d = {CW{1'b0}};
            end else begin
               v_pos_d = v_pos_q + CW'(1);
            end
         end else begin
            h_pos_d = h_pos_q + CW'(1);
         end
      end else begin
         h_pos_d = h_pos_q;
      end
      hde_d         = (h_pos_d < H_ACT);
      vde_d         = (v_pos_d < V_ACT);
      de_d          = hde_d & vde_d;
      hsync_d       = ((h_pos_d >= HS_BEG) && (h_pos_d < HS_END)) ? HS_POL : ~HS_POL;
      vsync_d       = ((v_pos_d >= VS_BEG) && (v_pos_d < VS_END)) ? VS_POL : ~VS_POL;
      line_start_d  = (h_pos_d == {CW{1'b0}});
      frame_start_d = line_start_d && (v_pos_d == {CW{1'b0}});
   end

   // Position and decoded-output registers; reset loads the (0,0) decode.
   always_ff @(posedge pclk) begin
      if (reset) begin
         h_pos_q       <= {CW{1'b0}};
         v_pos_q       <= {CW{1'b0}};
         hde_q         <= 1'b1;
         vde_q         <= 1'b1;
         de_q          <= 1'b1;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         line_start_q  <= 1'b1;
         frame_start_q <= 1'b1;
      end else begin
         h_pos_q       <= h_pos_d;
         v_pos_q       <= v_pos_d;
         hde_q         <= hde_d;
         vde_q         <= vde_d;
         de_q          <= de_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vt.pix_ena     = pix_ena_s;
   assign vt.h_pos       = h_pos_q;
   assign vt.v_pos       = v_pos_q;
   assign vt.hde         = hde_q;
   assign vt.vde         = vde_q;
   assign vt.de          = de_q;
   assign vt.hsync       = hsync_q;
   assign vt.vsync       = vsync_q;
   assign vt.line_start  = line_start_q;
   assign vt.frame_start = frame_start_q;
endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
// Two generators (active-high and active-low sync) share stimulus. The driver
// keeps a linear pixel-index model of the raster, pushes the expected outputs
// for each cycle into a queue, and a monitor pops and compares both DUTs.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;
   localparam int H_RES = 8, H_FP = 2, H_SYNC = 3, H_BP = 3;
   localparam int V_RES = 4, V_FP = 1, V_SYNC = 1, V_BP = 2;
   localparam int H_TOT = H_RES + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_RES + V_FP + V_SYNC + V_BP;
   localparam int FRAME = H_TOT * V_TOT;

   typedef struct {
      int h;
      int v;
      bit hde, vde, de, hs, vs, ls, fs, pe;
   } exp_t;

   logic pclk = 1'b0;
   logic reset = 1'b1;

   video_timing_gen_if #(.CW(12), .DIV_W(4)) vif_a ();
   video_timing_gen_if #(.CW(12), .DIV_W(4)) vif_b ();

   video_timing_gen #(
      .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(1'b1), .VS_POL(1'b1), .CW(12), .DIV_W(4)
   ) dut_a (.pclk(pclk), .reset(reset), .vt(vif_a));

   video_timing_gen #(
      .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(1'b0), .VS_POL(1'b0), .CW(12), .DIV_W(4)
   ) dut_b (.pclk(pclk), .reset(reset), .vt(vif_b));

   always #5 pclk = ~pclk;

   exp_t sb_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // reference model: linear pixel index in the frame plus pclk phase
   int m_p = 0, m_phase = 0, m_dq = 0;
   bit m_known = 1'b0;
   int cur_div = 0;

   task automatic step(input bit rst, input bit en, input int d);
      exp_t e;
      @(negedge pclk);
      reset        = rst;
      vif_a.enable = en;
      vif_b.enable = en;
      vif_a.div    = 4'(d);
      vif_b.div    = 4'(d);
      if (m_known) begin
         e.h   = m_p % H_TOT;
         e.v   = m_p / H_TOT;
         e.hde = (e.h < H_RES);
         e.vde = (e.v < V_RES);
         e.de  = e.hde && e.vde;
         e.hs  = (e.h >= H_RES + H_FP) && (e.h < H_RES + H_FP + H_SYNC);
         e.vs  = (e.v >= V_RES + V_FP) && (e.v < V_RES + V_FP + V_SYNC);
         e.ls  = (e.h == 0);
         e.fs  = (m_p == 0);
         e.pe  = en && (m_phase == m_dq);
         sb_q.push_back(e);
      end
      if (rst) begin
         m_p = 0; m_phase = 0; m_dq = d; m_known = 1'b1;
      end else if (m_known && en) begin
         if (m_phase == m_dq) begin
            m_phase = 0;
            m_p = (m_p + 1) % FRAME;
            if (m_p == 0) m_dq = d;
         end else begin
            m_phase = m_phase + 1;
         end
      end
   endtask

   task automatic run_until(input int target, input int budget, input int d);
      int n;
      n = 0;
      while (m_p != target && n < budget) begin
         step(1'b0, 1'b1, d);
         n++;
      end
      n_cmp++;
      if (m_p != target) begin
         n_fail++;
         $display("FAIL reach_position: model at %0d after %0d cycles, required %0d", m_p, n, target);
      end
   endtask

   logic [31:0] got_v, exp_v;
   exp_t        mon_e;

   // monitor: sample just before the next rising edge
   always @(negedge pclk) begin
      #4;
      if (sb_q.size() != 0) begin
         mon_e = sb_q.pop_front();
         got_v = {vif_a.h_pos, vif_a.v_pos, vif_a.hde, vif_a.vde, vif_a.de, vif_a.hsync,
                  vif_a.vsync, vif_a.line_start, vif_a.frame_start, vif_a.pix_ena};
         exp_v = {12'(mon_e.h), 12'(mon_e.v), mon_e.hde, mon_e.vde, mon_e.de, mon_e.hs,
                  mon_e.vs, mon_e.ls, mon_e.fs, mon_e.pe};
         n_cmp++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL pol_high t=%0t got h=%0d v=%0d hde,vde,de,hs,vs,ls,fs,pe=%b want h=%0d v=%0d flags=%b",
                     $time, got_v[31:20], got_v[19:8], got_v[7:0], exp_v[31:20], exp_v[19:8], exp_v[7:0]);
         end
         got_v = {vif_b.h_pos, vif_b.v_pos, vif_b.hde, vif_b.vde, vif_b.de, vif_b.hsync,
                  vif_b.vsync, vif_b.line_start, vif_b.frame_start, vif_b.pix_ena};
         exp_v = {12'(mon_e.h), 12'(mon_e.v), mon_e.hde, mon_e.vde, mon_e.de, !mon_e.hs,
                  !mon_e.vs, mon_e.ls, mon_e.fs, mon_e.pe};
         n_cmp++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL pol_low t=%0t got h=%0d v=%0d hde,vde,de,hs,vs,ls,fs,pe=%b want h=%0d v=%0d flags=%b",
                     $time, got_v[31:20], got_v[19:8], got_v[7:0], exp_v[31:20], exp_v[19:8], exp_v[7:0]);
         end
      end
   end

   initial begin
      vif_a.enable = 1'b1; vif_b.enable = 1'b1;
      vif_a.div    = 4'd0; vif_b.div    = 4'd0;

      // one pixel per pclk, a bit over two frames
      step(1'b1, 1'b1, 0);
      repeat (300) step(1'b0, 1'b1, 0);

      // divide by 4, two frames plus
      step(1'b1, 1'b1, 3);
      repeat (1100) step(1'b0, 1'b1, 3);

      // div change mid-frame at (5,3) takes effect at the next frame
      step(1'b1, 1'b1, 0);
      run_until(5 + 3 * H_TOT, 200, 0);
      repeat (FRAME + 2 * FRAME * 2) step(1'b0, 1'b1, 1);

      // freeze on the last position of the frame
      run_until(FRAME - 1, 2000, 1);
      repeat (7) step(1'b0, 1'b0, 1);
      repeat (40) step(1'b0, 1'b1, 1);

      // reset mid-frame at (9,5)
      run_until(9 + 5 * H_TOT, 2000, 1);
      step(1'b1, 1'b1, 1);
      repeat (60) step(1'b0, 1'b1, 1);

      // randomized enable, div and occasional reset
      cur_div = 1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 149) == 0) cur_div = $urandom_range(0, 3);
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0), cur_div);
      end

      repeat (2) @(negedge pclk);
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised video timing generator that produces pixel-clock enable, horizontal/vertical position counters, display enables and sync for any raster timing. It is the next-generation replacement for the fixed 640x480 sync generator and sits at the head of the video pipeline. Every downstream video sub-module consumes its `pix_ena`, position and enable outputs. Over the previous generation it adds:
- runtime pixel-clock division, latched only at frame boundaries;
- configurable sync polarity;
- exported pixel coordinates;
- line and frame markers;
- a freeze control.

## Interface
Parameters:
- `H_RES`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_RES`, 480, active lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync height (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 1, hsync active level (1 = active-high)
- `VS_POL`, 1, vsync active level
- `CW`, 12, position counter width
- `DIV_W`, 4, divider select width

Ports:
- `pclk`  in  1  base pixel clock; the only clock
- `reset`  in  1  synchronous, active-high; restarts the frame
- `enable`  in  1  high = run; low = freeze all state
- `div`  in  DIV_W  pixel period in pclks, minus 1 (0 = one pixel per pclk)
- `pix_ena`  out  1  high in the last pclk of each pixel period
- `h_pos`  out  CW  current pixel x
- `v_pos`  out  CW  current line y
- `hde`  out  1  h_pos < H_RES
- `vde`  out  1  v_pos < V_RES
- `de`  out  1  hde & vde
- `hsync`  out  1  horizontal sync at HS_POL level when active
- `vsync`  out  1  vertical sync at VS_POL level when active
- `line_start`  out  1  h_pos == 0
- `frame_start`  out  1  h_pos == 0 and v_pos == 0

## Operation
Totals are `H_TOT = H_RES+H_FP+H_SYNC+H_BP` and `V_TOT = V_RES+V_FP+V_SYNC+V_BP`.

**Divider**
- Internal `div_cnt` runs 0..`div_q`, then wraps to 0.
- `div_q` is the latched copy of `div`. It is loaded on reset and on the frame wrap tick only. A change to `div` mid-frame has no effect until the next frame.
- `pix_ena` is high exactly when `div_cnt == div_q`. With `div_q = 0`, `pix_ena` is permanently high.

**Counters** (advance on the pclk edge that ends a `pix_ena` cycle)
- `h_pos` counts 0..H_TOT-1 and wraps to 0.
- On the h wrap, `v_pos` increments. At V_TOT-1 it wraps to 0 instead; this is the frame wrap, where `div_q <= div`.

**Decoded outputs**
- All decoded outputs are registered. In every cycle they are exactly consistent with the current `h_pos`/`v_pos`; there is no one-pixel skew.
- hsync is active for `H_RES+H_FP <= h_pos < H_RES+H_FP+H_SYNC`.
- vsync is active for `V_RES+V_FP <= v_pos < V_RES+V_FP+V_SYNC`. vsync transitions therefore coincide with `h_pos = 0`.
- The inactive sync level is `~POL`.

**Freeze**
- While `enable` = 0: `div_cnt`, the counters and every output hold, and `pix_ena` is forced to 0.
- When `enable` returns to 1, counting resumes from the held `div_cnt`.

**Reset** (synchronous, takes priority over `enable`)
- Internal state: `div_cnt` = 0, `div_q` <= `div`.
- Outputs: `h_pos` = 0, `v_pos` = 0, `hde` = `vde` = `de` = 1, `line_start` = `frame_start` = 1, `hsync` = ~HS_POL, `vsync` = ~VS_POL.
- `pix_ena` = 1 if `div` = 0, else 0.
- A reset asserted mid-frame gives the same result on the next edge.

**Width rule:** elaboration fails (assertion) if `CW` cannot hold `H_TOT-1` or `V_TOT-1`, or if any porch or sync width is 0.

## Timing
- Each position lasts `div_q+1` pclks. A line is `H_TOT*(div_q+1)` pclks and a frame is `H_TOT*V_TOT*(div_q+1)` pclks.
- Latency from the reset release edge to the first position change is `div_q+1` pclks.
- `line_start` and `frame_start` are levels held for a whole pixel period. Consumers qualify them with `pix_ena` to get single-cycle pulses.
- Simultaneous frame wrap and `enable` low: the wrap does not occur, and `div_q` is not reloaded until the tick actually happens.
- Simultaneous reset and `enable` low: reset wins.

## Structure
- Package `video_timing_pkg` holds:
  - functions computing `H_TOT`/`V_TOT` and the sync start/end points from the parameters;
  - the polarity constants `SYNC_ACT_HIGH` and `SYNC_ACT_LOW`.
- One sub-module, `pix_ce_div`: the divider, with `div_q` latching and `enable` freeze. It outputs `pix_ena`.
- The top level holds the counters and registered decode.

## Test plan
Bench parameters: `H_RES`=8, `H_FP`=2, `H_SYNC`=3, `H_BP`=3 (`H_TOT`=16); `V_RES`=4, `V_FP`=1, `V_SYNC`=1, `V_BP`=2 (`V_TOT`=8).

1. Reset with `div`=0, `enable`=1 -> `h_pos` steps 0..15 each pclk; `hde` high for h 0..7; hsync high for h 10..12; vsync high for all of v=5; `frame_start` every 128 pclks.
2. Reset with `div`=3 -> `pix_ena` every 4th pclk; each position held 4 pclks; frame = 512 pclks.
3. `div` changed 0 -> 1 at (h,v) = (5,3) -> remainder of the frame still advances every pclk; from the next (0,0) onward each position lasts 2 pclks.
4. `enable` low for 7 pclks at (15,7) -> all outputs frozen and `pix_ena` = 0; after release, the next tick wraps to (0,0) with `frame_start` = 1.
5. Reset at (9,5) -> next cycle (0,0), `de` = 1, hsync and vsync inactive, `frame_start` = 1.
6. `HS_POL`=0, `VS_POL`=0 -> hsync low only for h 10..12; vsync low only for v=5; both high otherwise, including immediately after reset.
